// File: rtl/debounce_ctrl.sv
// Push-button debouncer: two-flop synchronizer plus a four-state qualifier that accepts a new level after STABLE_CYCLES samples.
// Level/pulse change lands STABLE_CYCLES+2 edges after a clean input step; no backpressure, outputs are free-running.
module debounce_ctrl #(
  parameter int STABLE_CYCLES = 100,
  parameter int CNT_WIDTH     = 7,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       noisy_in,
  input  logic       enable,
  output logic       debounced_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       busy,
  output logic [7:0] glitch_count
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } state_t;

  localparam state_t               RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST    = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 sync1_q;
  logic                 s_q;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 deb_q, deb_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [7:0]           glitch_q, glitch_d;
  logic                 glitch_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RESET_LEVEL;
      s_q     <= RESET_LEVEL;
    end else begin
      sync1_q <= noisy_in;
      s_q     <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RESET_STATE;
      cnt_q    <= '0;
      deb_q    <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      deb_q    <= deb_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  // Rule order inside a CHECK state matters: enable drop, then revert, then acceptance.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    deb_d      = deb_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (s_q && enable) state_d = CHECK_HIGH;
      end
      STABLE_HIGH: begin
        if (!s_q && enable) state_d = CHECK_LOW;
      end
      CHECK_HIGH: begin
        if (!enable) begin
          state_d = STABLE_LOW;
        end else if (!s_q) begin
          state_d    = STABLE_LOW;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          deb_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CHECK_LOW: begin
        if (!enable) begin
          state_d = STABLE_HIGH;
        end else if (s_q) begin
          state_d    = STABLE_HIGH;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          deb_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RESET_STATE;
    endcase
    glitch_d = (glitch_inc && (glitch_q != 8'hFF)) ? glitch_q + 8'd1 : glitch_q;
  end

  always_comb begin
    busy = (state_q == CHECK_HIGH) || (state_q == CHECK_LOW);
  end

  assign debounced_out = deb_q;
  assign rise_pulse    = rise_q;
  assign fall_pulse    = fall_q;
  assign glitch_count  = glitch_q;

endmodule

// File: tb/tb_debounce_ctrl.sv
// Scoreboard bench for debounce_ctrl: pulses expected at known edges are queued by stimulus and popped by a negedge monitor.
module tb_debounce_ctrl;

  logic       clk;
  logic       rst;
  logic       noisy_in, enable;
  logic       debounced_out, rise_pulse, fall_pulse, busy;
  logic [7:0] glitch_count;
  logic       noisy2, enable2;
  logic       deb2, rise2, fall2, busy2;
  logic [7:0] glitch2;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  int g     = 0;

  typedef struct {
    logic       rise;
    int         edge_n;
    logic [7:0] gl;
  } ev_t;
  ev_t exp_q[$];

  debounce_ctrl dut (
    .clk(clk), .rst(rst), .noisy_in(noisy_in), .enable(enable),
    .debounced_out(debounced_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .busy(busy), .glitch_count(glitch_count)
  );

  debounce_ctrl #(.STABLE_CYCLES(2), .CNT_WIDTH(2), .RESET_LEVEL(1'b1)) dut2 (
    .clk(clk), .rst(rst), .noisy_in(noisy2), .enable(enable2),
    .debounced_out(deb2), .rise_pulse(rise2), .fall_pulse(fall2),
    .busy(busy2), .glitch_count(glitch2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (rise_pulse || fall_pulse) begin
      chk("pulse_excl", {31'd0, rise_pulse & fall_pulse}, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", {31'd0, rise_pulse}, {31'd0, e.rise});
        chk("pulse_edge", ecnt, e.edge_n);
        chk("pulse_level", {31'd0, debounced_out}, {31'd0, e.rise});
        chk("pulse_glitch", {24'd0, glitch_count}, {24'd0, e.gl});
      end
    end
  end

  task automatic qualify(input logic v, input string tag);
    int e0;
    int nb;
    @(negedge clk);
    noisy_in = v;
    e0 = ecnt + 1;
    exp_q.push_back('{rise: v, edge_n: e0 + 102, gl: 8'(g)});
    nb = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      nb += int'(busy);
    end
    chk({tag, "_busy"}, nb, 100);
    chk({tag, "_lvl"}, {31'd0, debounced_out}, {31'd0, v});
    chk({tag, "_pend"}, exp_q.size(), 0);
  endtask

  initial begin
    int e0;
    int fe;
    int nf;
    rst = 1'b1; noisy_in = 1'b0; enable = 1'b1; noisy2 = 1'b1; enable2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_lvl",    {31'd0, debounced_out}, 0);
    chk("rst_rise",   {31'd0, rise_pulse}, 0);
    chk("rst_fall",   {31'd0, fall_pulse}, 0);
    chk("rst_busy",   {31'd0, busy}, 0);
    chk("rst_glitch", {24'd0, glitch_count}, 0);
    chk("rst_lvl2",   {31'd0, deb2}, 1);
    @(negedge clk);
    rst = 1'b0;

    qualify(1'b1, "press");
    qualify(1'b0, "release");

    // Input held for exactly 100 edges: s reverts at the cycle cnt reaches 99.
    @(negedge clk);
    noisy_in = 1'b1;
    repeat (100) @(negedge clk);
    noisy_in = 1'b0;
    g++;
    repeat (10) @(negedge clk);
    chk("bnd_glitch", {24'd0, glitch_count}, g);
    chk("bnd_lvl", {31'd0, debounced_out}, 0);
    chk("bnd_pend", exp_q.size(), 0);

    // One edge longer is enough to accept, then the low step qualifies back.
    @(negedge clk);
    noisy_in = 1'b1;
    e0 = ecnt + 1;
    exp_q.push_back('{rise: 1'b1, edge_n: e0 + 102, gl: 8'(g)});
    repeat (101) @(negedge clk);
    noisy_in = 1'b0;
    exp_q.push_back('{rise: 1'b0, edge_n: e0 + 101 + 102, gl: 8'(g)});
    repeat (220) @(negedge clk);
    chk("bnd1_pend", exp_q.size(), 0);
    chk("bnd1_lvl", {31'd0, debounced_out}, 0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk); noisy_in = 1'b1;
      repeat (9) @(negedge clk); noisy_in = 1'b0;
      repeat (9) @(negedge clk);
    end
    g += 4;
    @(negedge clk);
    noisy_in = 1'b1;
    e0 = ecnt + 1;
    exp_q.push_back('{rise: 1'b1, edge_n: e0 + 102, gl: 8'(g)});
    repeat (120) @(negedge clk);
    chk("bounce_glitch", {24'd0, glitch_count}, g);
    chk("bounce_pend", exp_q.size(), 0);

    // Enable dropped when cnt=50 in CHECK_LOW, then restored with the input still low.
    @(negedge clk);
    noisy_in = 1'b0;
    repeat (53) @(negedge clk);
    chk("en_busy_before", {31'd0, busy}, 1);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    chk("en_busy_off", {31'd0, busy}, 0);
    chk("en_glitch", {24'd0, glitch_count}, g);
    chk("en_lvl_hold", {31'd0, debounced_out}, 1);
    enable = 1'b1;
    exp_q.push_back('{rise: 1'b0, edge_n: ecnt + 1 + 100, gl: 8'(g)});
    repeat (120) @(negedge clk);
    chk("en_pend", exp_q.size(), 0);
    chk("en_lvl", {31'd0, debounced_out}, 0);

    // Reset asserted mid-cycle once cnt=60 in CHECK_HIGH.
    @(negedge clk);
    noisy_in = 1'b1;
    repeat (63) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 1);
    #2 rst = 1'b1;
    #1;
    g = 0;
    chk("mid_rst_lvl",    {31'd0, debounced_out}, 0);
    chk("mid_rst_busy",   {31'd0, busy}, 0);
    chk("mid_rst_pulse",  {30'd0, rise_pulse, fall_pulse}, 0);
    chk("mid_rst_glitch", {24'd0, glitch_count}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{rise: 1'b1, edge_n: ecnt + 1 + 102, gl: 8'(g)});
    repeat (120) @(negedge clk);
    chk("mid_pend", exp_q.size(), 0);
    chk("mid_lvl", {31'd0, debounced_out}, 1);

    for (int i = 0; i < 300; i++) begin
      noisy_in = 1'b0;
      repeat (3) @(negedge clk);
      noisy_in = 1'b1;
      repeat (3) @(negedge clk);
      g = (g < 255) ? g + 1 : 255;
      if (i == 253 || i == 254 || i == 299)
        chk("sat_glitch", {24'd0, glitch_count}, g);
    end
    chk("sat_lvl", {31'd0, debounced_out}, 1);

    @(negedge clk);
    noisy2 = 1'b0;
    e0 = ecnt + 1;
    fe = -1;
    nf = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fall2) begin
        nf++;
        fe = ecnt;
      end
    end
    chk("p2_fall_edge", fe, e0 + 4);
    chk("p2_fall_count", nf, 1);
    chk("p2_lvl", {31'd0, deb2}, 0);

    chk("final_pend", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
